// File: rtl/issue_age_tracker_pkg.sv
// Shared widths, age encodings and helpers for the issue-window age tracker.
package issue_age_tracker_pkg;

    localparam int DEFAULT_NUM_ENTRIES     = 8;
    localparam int DEFAULT_ENTRY_PTR_WIDTH = 3;
    localparam int DEFAULT_AGE_WIDTH       = 3;
    localparam int MAX_ENTRIES             = 16;

    // Age 0 marks a slot the selector must never prefer; live slots start at 1.
    localparam int AGE_INVALID  = 0;
    localparam int AGE_ON_ALLOC = 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] age, input int width);
        logic [31:0] age_max;
        age_max = (32'd1 << width) - 32'd1;
        return (age >= age_max) ? age : age + 32'd1;
    endfunction

    function automatic int lowest_set(input logic [MAX_ENTRIES-1:0] mask);
        int idx;
        idx = 0;
        for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/issue_age_tracker_free_slot_encoder.sv
// Lowest-index free-slot finder; output depends on registered valid bits only.
module free_slot_encoder
    import issue_age_tracker_pkg::*;
#(
    parameter int NUM_ENTRIES     = DEFAULT_NUM_ENTRIES,
    parameter int ENTRY_PTR_WIDTH = DEFAULT_ENTRY_PTR_WIDTH
) (
    input  logic [NUM_ENTRIES-1:0]     valid_i,
    output logic [ENTRY_PTR_WIDTH-1:0] alloc_ptr_o,
    output logic                       alloc_ready_o
);

    logic [MAX_ENTRIES-1:0] free_ext;

    always_comb begin
        free_ext                    = '0;
        free_ext[NUM_ENTRIES-1:0]   = ~valid_i;
        alloc_ready_o               = |free_ext;
        alloc_ptr_o                 = ENTRY_PTR_WIDTH'(lowest_set(free_ext));
    end

endmodule

// File: rtl/issue_age_tracker.sv
// Per-slot valid/ready/age state for an issue window, closing the loop around
// an external compare-select stage that returns the oldest eligible slot.
module issue_age_tracker
    import issue_age_tracker_pkg::*;
#(
    parameter int NUM_ENTRIES     = DEFAULT_NUM_ENTRIES,
    parameter int ENTRY_PTR_WIDTH = DEFAULT_ENTRY_PTR_WIDTH,
    parameter int AGE_WIDTH       = DEFAULT_AGE_WIDTH
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             flush_in,
    input  logic                             alloc_valid_in,
    output logic                             alloc_ready_out,
    output logic [ENTRY_PTR_WIDTH-1:0]       alloc_ptr_out,
    input  logic                             wake_valid_in,
    input  logic [ENTRY_PTR_WIDTH-1:0]       wake_ptr_in,
    input  logic                             age_tick_in,
    output logic [NUM_ENTRIES-1:0]           condition_out,
    output logic [AGE_WIDTH*NUM_ENTRIES-1:0] ages_out,
    input  logic [ENTRY_PTR_WIDTH-1:0]       selected_ptr_in,
    output logic                             issue_valid_out,
    output logic [ENTRY_PTR_WIDTH-1:0]       issue_ptr_out,
    input  logic                             issue_ack_in,
    output logic [ENTRY_PTR_WIDTH:0]         occupancy_out
);

    localparam int OCC_WIDTH = ENTRY_PTR_WIDTH + 1;

    logic [NUM_ENTRIES-1:0]                valid_vec;
    logic [NUM_ENTRIES-1:0]                ready_vec;
    logic [NUM_ENTRIES-1:0][AGE_WIDTH-1:0] age_vec;
    logic                                  alloc_fire;
    logic                                  ack_fire;
    logic [OCC_WIDTH-1:0]                  occ_q, occ_d;

    free_slot_encoder #(
        .NUM_ENTRIES     (NUM_ENTRIES),
        .ENTRY_PTR_WIDTH (ENTRY_PTR_WIDTH)
    ) u_free_slot_encoder (
        .valid_i       (valid_vec),
        .alloc_ptr_o   (alloc_ptr_out),
        .alloc_ready_o (alloc_ready_out)
    );

    assign condition_out   = valid_vec & ready_vec;
    assign ages_out        = age_vec;
    assign issue_valid_out = |condition_out;
    assign issue_ptr_out   = selected_ptr_in;
    assign alloc_fire      = alloc_valid_in & alloc_ready_out;
    assign ack_fire        = issue_ack_in & issue_valid_out;
    assign occupancy_out   = occ_q;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
        logic                 valid_q, valid_d;
        logic                 ready_q, ready_d;
        logic [AGE_WIDTH-1:0] age_q, age_d;
        logic                 alloc_hit, ack_hit, wake_hit;

        assign alloc_hit = alloc_fire && (alloc_ptr_out == ENTRY_PTR_WIDTH'(i));
        assign ack_hit   = ack_fire && (selected_ptr_in == ENTRY_PTR_WIDTH'(i));
        assign wake_hit  = wake_valid_in && valid_q && (wake_ptr_in == ENTRY_PTR_WIDTH'(i));

        // Ack beats wake; alloc only ever targets a free slot so it cannot meet ack.
        always_comb begin
            valid_d = valid_q;
            ready_d = ready_q | wake_hit;
            age_d   = age_q;
            if (ack_hit) begin
                valid_d = 1'b0;
                ready_d = 1'b0;
                age_d   = AGE_WIDTH'(AGE_INVALID);
            end else if (alloc_hit) begin
                valid_d = 1'b1;
                ready_d = 1'b0;
                age_d   = AGE_WIDTH'(AGE_ON_ALLOC);
            end else if (age_tick_in && valid_q) begin
                age_d   = AGE_WIDTH'(sat_inc(32'(age_q), AGE_WIDTH));
            end
        end

        always_ff @(posedge clk_in) begin
            if (reset_in || flush_in) begin
                valid_q <= 1'b0;
                ready_q <= 1'b0;
                age_q   <= AGE_WIDTH'(AGE_INVALID);
            end else begin
                valid_q <= valid_d;
                ready_q <= ready_d;
                age_q   <= age_d;
            end
        end

        assign valid_vec[i] = valid_q;
        assign ready_vec[i] = ready_q;
        assign age_vec[i]   = age_q;
    end

    always_comb begin
        occ_d = occ_q;
        if (alloc_fire && !ack_fire) begin
            occ_d = occ_q + OCC_WIDTH'(1);
        end else if (!alloc_fire && ack_fire) begin
            occ_d = occ_q - OCC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || flush_in) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // The selector must only ever hand back an eligible slot.
    assert property (@(posedge clk_in) disable iff (reset_in)
                     issue_valid_out |-> condition_out[selected_ptr_in]);

endmodule

// File: tb/tb_issue_age_tracker.sv
// Directed bench for issue_age_tracker with a simple oldest-first selector model.
module tb_issue_age_tracker;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int AW = 3;

    logic            clk_in = 1'b0;
    logic            reset_in, flush_in;
    logic            alloc_valid_in, alloc_ready_out;
    logic [PW-1:0]   alloc_ptr_out;
    logic            wake_valid_in;
    logic [PW-1:0]   wake_ptr_in;
    logic            age_tick_in;
    logic [N-1:0]    condition_out;
    logic [AW*N-1:0] ages_out;
    logic [PW-1:0]   selected_ptr_in;
    logic            issue_valid_out;
    logic [PW-1:0]   issue_ptr_out;
    logic            issue_ack_in;
    logic [PW:0]     occupancy_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    issue_age_tracker #(
        .NUM_ENTRIES     (N),
        .ENTRY_PTR_WIDTH (PW),
        .AGE_WIDTH       (AW)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .flush_in        (flush_in),
        .alloc_valid_in  (alloc_valid_in),
        .alloc_ready_out (alloc_ready_out),
        .alloc_ptr_out   (alloc_ptr_out),
        .wake_valid_in   (wake_valid_in),
        .wake_ptr_in     (wake_ptr_in),
        .age_tick_in     (age_tick_in),
        .condition_out   (condition_out),
        .ages_out        (ages_out),
        .selected_ptr_in (selected_ptr_in),
        .issue_valid_out (issue_valid_out),
        .issue_ptr_out   (issue_ptr_out),
        .issue_ack_in    (issue_ack_in),
        .occupancy_out   (occupancy_out)
    );

    // Compare-select stand-in: highest age among eligible slots, lowest index on ties.
    always_comb begin
        logic [AW-1:0] best;
        best            = '0;
        selected_ptr_in = '0;
        for (int i = 0; i < N; i++) begin
            if (condition_out[i] && (ages_out[i*AW +: AW] > best)) begin
                best            = ages_out[i*AW +: AW];
                selected_ptr_in = PW'(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        reset_in       = 1'b0;
        flush_in       = 1'b0;
        alloc_valid_in = 1'b0;
        wake_valid_in  = 1'b0;
        wake_ptr_in    = '0;
        age_tick_in    = 1'b0;
        issue_ack_in   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
    endtask

    task automatic alloc1();
        alloc_valid_in = 1'b1;
        step();
        alloc_valid_in = 1'b0;
    endtask

    task automatic tick1();
        age_tick_in = 1'b1;
        step();
        age_tick_in = 1'b0;
    endtask

    task automatic wake1(input logic [PW-1:0] p);
        wake_valid_in = 1'b1;
        wake_ptr_in   = p;
        step();
        wake_valid_in = 1'b0;
    endtask

    task automatic ack1();
        issue_ack_in = 1'b1;
        step();
        issue_ack_in = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(alloc_ready_out), 32'd1);
        chk({tag, "_ptr"},   32'(alloc_ptr_out),   32'd0);
        chk({tag, "_cond"},  32'(condition_out),   32'd0);
        chk({tag, "_ages"},  32'(ages_out),        32'd0);
        chk({tag, "_ivld"},  32'(issue_valid_out), 32'd0);
        chk({tag, "_occ"},   32'(occupancy_out),   32'd0);
    endtask

    initial begin
        idle_inputs();
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
        chk_reset_state("rst");

        // Three allocations fill slots 0..2 in order, none eligible yet.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("alloc_ptr%0d", k), 32'(alloc_ptr_out), k);
            alloc1();
        end
        chk("alloc3_occ",  32'(occupancy_out),   32'd3);
        chk("alloc3_ivld", 32'(issue_valid_out), 32'd0);
        chk("alloc3_ages", 32'(ages_out),        32'h49);

        // Staggered ticks give ages 3,2,1; oldest wins and is freed by ack.
        do_reset();
        alloc1();
        tick1();
        alloc1();
        tick1();
        alloc1();
        chk("stag_ages_pre", 32'(ages_out), 32'h53);
        chk("stag_cond_pre", 32'(condition_out), 32'h00);
        wake1(3'd0);
        chk("wake_latency", 32'(issue_valid_out), 32'd1);
        wake1(3'd1);
        wake1(3'd2);
        wake1(3'd7);
        chk("stag_cond", 32'(condition_out), 32'h07);
        chk("stag_ages", 32'(ages_out),      32'h53);
        chk("stag_iptr", 32'(issue_ptr_out), 32'd0);
        ack1();
        chk("stag_ack_cond",  32'(condition_out), 32'h06);
        chk("stag_ack_ages",  32'(ages_out),      32'h50);
        chk("stag_ack_occ",   32'(occupancy_out), 32'd2);
        chk("stag_ack_aptr",  32'(alloc_ptr_out), 32'd0);
        chk("stag_next_iptr", 32'(issue_ptr_out), 32'd1);

        // Full window: extra alloc ignored, freeing slot 5 makes it the next grant.
        do_reset();
        for (int k = 0; k < N; k++) alloc1();
        chk("full_ready", 32'(alloc_ready_out), 32'd0);
        chk("full_occ",   32'(occupancy_out),   32'd8);
        alloc1();
        chk("full_extra_occ", 32'(occupancy_out), 32'd8);
        wake1(3'd5);
        chk("full_iptr", 32'(issue_ptr_out), 32'd5);
        ack1();
        chk("full_ack_ready", 32'(alloc_ready_out), 32'd1);
        chk("full_ack_aptr",  32'(alloc_ptr_out),   32'd5);
        chk("full_ack_occ",   32'(occupancy_out),   32'd7);

        // Saturation at 7 with no wrap.
        do_reset();
        alloc1();
        for (int k = 0; k < 5; k++) tick1();
        chk("sat_mid", 32'(ages_out), 32'd6);
        for (int k = 0; k < 5; k++) tick1();
        chk("sat_top", 32'(ages_out), 32'd7);

        // Alloc + ack + tick in one cycle.
        alloc1();
        wake1(3'd0);
        chk("combo_pre_iptr", 32'(issue_ptr_out), 32'd0);
        alloc_valid_in = 1'b1;
        issue_ack_in   = 1'b1;
        age_tick_in    = 1'b1;
        step();
        idle_inputs();
        chk("combo_occ",  32'(occupancy_out), 32'd2);
        chk("combo_ages", 32'(ages_out),      32'h50);
        chk("combo_cond", 32'(condition_out), 32'h00);
        chk("combo_aptr", 32'(alloc_ptr_out), 32'd0);

        // Wake and ack on the same slot: ack wins.
        wake1(3'd1);
        chk("wa_pre_cond", 32'(condition_out), 32'h02);
        issue_ack_in  = 1'b1;
        wake_valid_in = 1'b1;
        wake_ptr_in   = 3'd1;
        step();
        idle_inputs();
        chk("wa_cond", 32'(condition_out), 32'h00);
        chk("wa_occ",  32'(occupancy_out), 32'd1);
        chk("wa_ages", 32'(ages_out),      32'h40);

        // Wake to the slot being allocated is ignored.
        alloc_valid_in = 1'b1;
        wake_valid_in  = 1'b1;
        wake_ptr_in    = 3'd0;
        step();
        idle_inputs();
        chk("wal_cond", 32'(condition_out), 32'h00);
        chk("wal_occ",  32'(occupancy_out), 32'd2);
        chk("wal_aptr", 32'(alloc_ptr_out), 32'd1);

        // Flush with four valid slots beats a concurrent alloc.
        alloc1();
        alloc1();
        wake1(3'd2);
        chk("fl_pre_occ", 32'(occupancy_out), 32'd4);
        flush_in       = 1'b1;
        alloc_valid_in = 1'b1;
        age_tick_in    = 1'b1;
        step();
        idle_inputs();
        chk_reset_state("flush");

        // Reset beats an alloc in the same cycle.
        alloc1();
        alloc1();
        reset_in       = 1'b1;
        alloc_valid_in = 1'b1;
        step();
        idle_inputs();
        chk_reset_state("rst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_age_tracker.md
Name: issue_age_tracker

Overview:
- Holds per-entry state for an N-slot issue window: valid, ready and a saturating age counter.
- Drives the compare-select stage with the flattened age vector and the ready mask.
- Takes back the winning pointer from that stage, presents it as an issue request, and frees the slot on acknowledge.
- Sits directly upstream of the compare-select stage and closes the loop around it; the select path is combinational within one cycle.

Parameters:
NUM_ENTRIES, 8, number of window slots; power of two, 1..16
ENTRY_PTR_WIDTH, 3, slot index width; equals log2(NUM_ENTRIES), minimum 1
AGE_WIDTH, 3, age counter width; age 0 is reserved to mean "not eligible"

Ports:
clk_in  input  1  single clock
reset_in  input  1  synchronous reset, active-high
flush_in  input  1  clears all slots next edge
alloc_valid_in  input  1  request to allocate one slot
alloc_ready_out  output  1  at least one free slot
alloc_ptr_out  output  ENTRY_PTR_WIDTH  slot granted; lowest-index free slot
wake_valid_in  input  1  mark a slot ready
wake_ptr_in  input  ENTRY_PTR_WIDTH  slot to wake
age_tick_in  input  1  advance ages of all valid slots
condition_out  output  NUM_ENTRIES  valid & ready per slot, to selector condition_in
ages_out  output  AGE_WIDTH*NUM_ENTRIES  per-slot age, slot i at bits [(i+1)*AGE_WIDTH-1 : i*AGE_WIDTH], to selector elements_in
selected_ptr_in  input  ENTRY_PTR_WIDTH  winner pointer from selector
issue_valid_out  output  1  OR of condition_out
issue_ptr_out  output  ENTRY_PTR_WIDTH  equals selected_ptr_in
issue_ack_in  input  1  consumer took issue_ptr_out; free that slot
occupancy_out  output  ENTRY_PTR_WIDTH+1  count of valid slots

Behaviour:
- Reset and flush have the same effect: all valid, ready and age bits go to 0 at the next edge.
  - Resulting outputs: alloc_ready_out=1, alloc_ptr_out=0, condition_out=0, ages_out=0, issue_valid_out=0, occupancy_out=0.
  - reset_in has priority over every other input; flush_in has priority over alloc, wake, tick and ack.
- Allocation completes when alloc_valid_in and alloc_ready_out are both high at an edge.
  - The slot at alloc_ptr_out is set valid=1, ready=0, age=1.
  - alloc_ptr_out and alloc_ready_out are combinational from registered state only; they never depend on same-cycle ack.
  - When the window is full, alloc_ready_out=0 and the request is ignored.
- Wake: when wake_valid_in is high and the slot is valid, the slot's ready bit is set at the edge.
  - A wake to an invalid slot is ignored.
  - A wake to an already-ready slot has no effect.
- Aging: on age_tick_in, every valid slot not being allocated in the same cycle increments its age.
  - Increment saturates at 2^AGE_WIDTH-1.
  - Invalid slots stay at age 0.
  - A slot allocated in the same cycle as a tick gets age=1.
- Age 0 is never held by a valid slot, so masked-out slots never tie an eligible slot at the selector. Among saturated slots the selector breaks ties; any tied eligible slot is acceptable.
- Issue:
  - issue_valid_out = |condition_out and issue_ptr_out = selected_ptr_in, both combinational.
  - On issue_ack_in with issue_valid_out=1, the slot at selected_ptr_in is cleared (valid=0, ready=0, age=0) at the edge.
  - issue_ack_in is ignored when issue_valid_out=0.
  - The tracker asserts (simulation only) that selected_ptr_in indexes a slot with condition_out=1 whenever issue_valid_out=1.
- Simultaneous events:
  - Alloc and ack in one cycle: both take effect; occupancy is unchanged.
  - The allocated slot is always free, so it never collides with the acked slot.
  - Wake and ack to the same slot: ack wins, and the slot ends invalid.
  - Wake to the slot being allocated in the same cycle is ignored, because the slot is not yet valid.
- occupancy_out is registered: incremented on alloc, decremented on ack, unchanged on both or neither, cleared on flush and reset.
- Latency:
  - Alloc → condition visible: after a wake, one edge.
  - Wake → issue_valid_out: one cycle.
  - Ack → slot free, visible on alloc_ptr_out: next cycle.

Decomposition:
- Shared package holds:
  - default widths;
  - the constant AGE_INVALID=0 and the constant AGE_ON_ALLOC=1;
  - a function for saturating increment;
  - a function for lowest-set-bit priority encode of the free mask.
- One natural sub-module, free_slot_encoder: combinational lowest-index encoder over ~valid, producing alloc_ptr_out and alloc_ready_out.
- Per-slot state is a generate loop in the top.

Test Plan:
- Reset then alloc ×3, no wake → alloc_ptr_out 0,1,2 in successive cycles; occupancy_out=3; issue_valid_out=0; ages_out slots 0..2 = 1.
- Alloc slots 0,1,2; tick ×2 after slot 0, tick ×1 after slot 1, none after slot 2; wake all; tie compare-select in → condition_out=8'b0000_0111, ages 3,2,1; issue_ptr_out=0; ack frees slot 0; next alloc_ptr_out=0.
- Fill all 8 slots → alloc_ready_out=0; extra alloc_valid_in ignored with occupancy_out=8; ack slot 5 → alloc_ready_out=1, alloc_ptr_out=5 next cycle.
- One slot with 10 ticks at AGE_WIDTH=3 → age saturates at 7, no wrap to 0.
- Same-cycle alloc+ack+tick → occupancy unchanged; new slot age=1; acked slot age=0 and invalid.
- Wake and ack same slot in one cycle → slot invalid. Flush with 4 valid slots → all outputs at reset values next cycle. reset_in mid-alloc → reset wins.
